// File: rtl/vga_timing_gen_pkg.sv
// Shared constants and types for the VGA raster timing block.
package vga_pkg;

    localparam int COORD_W = 10;
    localparam int RGB_W   = 8;

    // Default 640x480@60 Hz timing: pixels horizontally, lines vertically.
    localparam int DEF_CLK_DIV  = 4;
    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_H_FP     = 16;
    localparam int DEF_H_SYNC   = 96;
    localparam int DEF_H_BP     = 48;
    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_V_FP     = 10;
    localparam int DEF_V_SYNC   = 2;
    localparam int DEF_V_BP     = 33;
    localparam int DEF_PIPE_LAT = 3;

    // Sum of the four timing phases of one axis.
    function automatic int axis_total(input int active, input int fp, input int sync, input int bp);
        return active + fp + sync + bp;
    endfunction

    localparam int H_TOTAL = axis_total(DEF_H_ACTIVE, DEF_H_FP, DEF_H_SYNC, DEF_H_BP);
    localparam int V_TOTAL = axis_total(DEF_V_ACTIVE, DEF_V_FP, DEF_V_SYNC, DEF_V_BP);

    typedef logic [COORD_W-1:0] coord_t;
    typedef logic [RGB_W-1:0]   rgb_t;

    // Blank/sync flags that travel through the latency-matching delay line.
    typedef struct packed {
        logic act;
        logic hs;
        logic vs;
    } sync_bits_t;

    // Idle raster state: blanked, both syncs inactive (high).
    localparam sync_bits_t SYNC_IDLE = '{act: 1'b0, hs: 1'b1, vs: 1'b1};

endpackage

// File: rtl/vga_timing_gen_if.sv
// Raster-side bundle between the timing generator, the sprite pipeline and the DAC.
interface vga_timing_gen_if;
    import vga_pkg::*;

    coord_t x;
    coord_t y;
    logic   en;
    logic   pix_tick;
    logic   frame_start;
    rgb_t   rgb_in;
    rgb_t   vga_rgb;
    logic   hsync;
    logic   vsync;

    // Timing generator side.
    modport master (
        output x, y, en, pix_tick, frame_start, vga_rgb, hsync, vsync,
        input  rgb_in
    );

    // Sprite pipeline / connector side.
    modport slave (
        input  x, y, en, pix_tick, frame_start, vga_rgb, hsync, vsync,
        output rgb_in
    );
endinterface

// File: rtl/vga_timing_gen_sync_delay.sv
// WIDTH x DEPTH shift register with a per-bit reset value; DEPTH=0 is a wire.
module sync_delay #(
    parameter int               WIDTH   = 3,
    parameter int               DEPTH   = 3,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    if (DEPTH == 0) begin : g_bypass
        // clk/rst_n have no function without stages; fold them into a dead net.
        logic bypass_unused;
        assign bypass_unused = clk ^ rst_n;
        assign dout          = din;
    end else begin : g_pipe
        logic [WIDTH-1:0] stage [DEPTH];

        // Shift the flags one stage per clk.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                // NOTE: every stage is reset, not just the output, so no stale sync pulse can leak out after reset.
                for (int i = 0; i < DEPTH; i++) stage[i] <= RST_VAL;
            end else begin
                // NOTE: non-blocking assignments make all stages sample their pre-edge neighbour, giving a true shift.
                stage[0] <= din;
                for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
            end
        end

        assign dout = stage[DEPTH-1];
    end

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing: pixel divider, x/y counters, sync decode, latency-matched output stage.
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int CLK_DIV  = DEF_CLK_DIV,
    parameter int H_ACTIVE = DEF_H_ACTIVE,
    parameter int H_FP     = DEF_H_FP,
    parameter int H_SYNC   = DEF_H_SYNC,
    parameter int H_BP     = DEF_H_BP,
    parameter int V_ACTIVE = DEF_V_ACTIVE,
    parameter int V_FP     = DEF_V_FP,
    parameter int V_SYNC   = DEF_V_SYNC,
    parameter int V_BP     = DEF_V_BP,
    parameter int PIPE_LAT = DEF_PIPE_LAT
) (
    input logic              clk,
    input logic              rst_n,
    vga_timing_gen_if.master vif
);

    localparam int     H_TOT    = axis_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int     V_TOT    = axis_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
    localparam coord_t H_LAST   = coord_t'(H_TOT - 1);
    localparam coord_t V_LAST   = coord_t'(V_TOT - 1);
    localparam coord_t H_ACT_C  = coord_t'(H_ACTIVE);
    localparam coord_t V_ACT_C  = coord_t'(V_ACTIVE);
    localparam coord_t HS_START = coord_t'(H_ACTIVE + H_FP);
    localparam coord_t HS_END   = coord_t'(H_ACTIVE + H_FP + H_SYNC);
    localparam coord_t VS_START = coord_t'(V_ACTIVE + V_FP);
    localparam coord_t VS_END   = coord_t'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [3:0] DIV_LAST = 4'(CLK_DIV - 1);

    logic [3:0] div_cnt;
    logic       pix_tick;
    coord_t     x, y;
    logic       frame_start;
    logic       en, hs_raw, vs_raw;
    sync_bits_t raw_bits, dly_bits;
    rgb_t       vga_rgb;
    logic       hsync, vsync;

    assign pix_tick = (div_cnt == DIV_LAST);

    // Pixel-rate divider: counts 0..CLK_DIV-1 and wraps on the tick.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) div_cnt <= '0;
        else        div_cnt <= pix_tick ? '0 : div_cnt + 4'd1;
    end

    // Raster counters; frame_start is a one-clk pulse on the (last,last) -> (0,0) wrap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x           <= '0;
            y           <= '0;
            frame_start <= 1'b0;
        end else begin
            frame_start <= 1'b0;
            if (pix_tick) begin
                if (x == H_LAST) begin
                    x <= '0;
                    if (y == V_LAST) begin
                        y           <= '0;
                        frame_start <= 1'b1;
                    end else begin
                        y <= y + 1'b1;
                    end
                end else begin
                    x <= x + 1'b1;
                end
            end
        end
    end

    // Combinational decode of active video and raw (undelayed) syncs.
    always_comb begin
        // NOTE: defaults first so every path assigns every output and no latch is inferred.
        hs_raw = 1'b1;
        vs_raw = 1'b1;
        en     = (x < H_ACT_C) && (y < V_ACT_C);
        if (x >= HS_START && x < HS_END) hs_raw = 1'b0;
        if (y >= VS_START && y < VS_END) vs_raw = 1'b0;
    end

    assign raw_bits = '{act: en, hs: hs_raw, vs: vs_raw};

    sync_delay #(
        .WIDTH   (3),
        .DEPTH   (PIPE_LAT),
        .RST_VAL (SYNC_IDLE)
    ) u_sync_delay (
        .clk   (clk),
        .rst_n (rst_n),
        .din   (raw_bits),
        .dout  (dly_bits)
    );

    // Output register: syncs and blanked colour leave together, aligned with the sprite latency.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hsync   <= 1'b1;
            vsync   <= 1'b1;
            vga_rgb <= '0;
        end else begin
            hsync   <= dly_bits.hs;
            vsync   <= dly_bits.vs;
            vga_rgb <= dly_bits.act ? vif.rgb_in : '0;
        end
    end

    assign vif.x           = x;
    assign vif.y           = y;
    assign vif.en          = en;
    assign vif.pix_tick    = pix_tick;
    assign vif.frame_start = frame_start;
    assign vif.vga_rgb     = vga_rgb;
    assign vif.hsync       = hsync;
    assign vif.vsync       = vsync;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench: a full-size 640x480 instance (CLK_DIV=4, PIPE_LAT=3) for line timing and
// alignment, and a tiny-raster instance (CLK_DIV=1, PIPE_LAT=0) for whole-frame and reset cases.
module tb_vga_timing_gen;

    logic clk = 1'b0;
    logic rst_n;
    logic ramp;
    logic [7:0] d1, d2, d3;
    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    vga_timing_gen_if a_if ();
    vga_timing_gen_if b_if ();

    // Sprite-pipeline stand-in: x[7:0] delayed 3 clk, or a constant white.
    always @(posedge clk) begin
        d1 <= a_if.x[7:0];
        d2 <= d1;
        d3 <= d2;
    end
    assign a_if.rgb_in = ramp ? d3 : 8'hFF;
    assign b_if.rgb_in = 8'hFF;

    vga_timing_gen dut_a (
        .clk   (clk),
        .rst_n (rst_n),
        .vif   (a_if)
    );

    vga_timing_gen #(
        .CLK_DIV (1),
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
        .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(1),
        .PIPE_LAT(0)
    ) dut_b (
        .clk   (clk),
        .rst_n (rst_n),
        .vif   (b_if)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        int         n;      // clk edges since reset release
        logic [9:0] x;
        logic [9:0] y;
        logic       tick;
        logic       en;
        logic       hs;
        logic       vs;
        logic [7:0] rgb;
    } vec_t;

    vec_t vec [12];

    initial begin
        int cur;
        int bad_rgb, bad_hs, hs_low, hs_fall, vs_low;
        logic [7:0] first_px, last_px;
        int bad_xy, bad_bhs, bad_bvs, bad_brgb, bad_fs, fs_cnt, fs_first, fs_second;

        // Full-size instance, rgb_in tied to FF: hand-computed sample points of line 0 / line 1.
        vec[0]  = '{0,    10'd0,   10'd0, 1'b0, 1'b1, 1'b1, 1'b1, 8'h00};
        vec[1]  = '{3,    10'd0,   10'd0, 1'b1, 1'b1, 1'b1, 1'b1, 8'h00};
        vec[2]  = '{4,    10'd1,   10'd0, 1'b0, 1'b1, 1'b1, 1'b1, 8'hFF};
        vec[3]  = '{2563, 10'd640, 10'd0, 1'b1, 1'b0, 1'b1, 1'b1, 8'hFF};
        vec[4]  = '{2564, 10'd641, 10'd0, 1'b0, 1'b0, 1'b1, 1'b1, 8'h00};
        vec[5]  = '{2627, 10'd656, 10'd0, 1'b1, 1'b0, 1'b1, 1'b1, 8'h00};
        vec[6]  = '{2628, 10'd657, 10'd0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00};
        vec[7]  = '{3011, 10'd752, 10'd0, 1'b1, 1'b0, 1'b0, 1'b1, 8'h00};
        vec[8]  = '{3012, 10'd753, 10'd0, 1'b0, 1'b0, 1'b1, 1'b1, 8'h00};
        vec[9]  = '{3199, 10'd799, 10'd0, 1'b1, 1'b0, 1'b1, 1'b1, 8'h00};
        vec[10] = '{3200, 10'd0,   10'd1, 1'b0, 1'b1, 1'b1, 1'b1, 8'h00};
        vec[11] = '{3204, 10'd1,   10'd1, 1'b0, 1'b1, 1'b1, 1'b1, 8'hFF};

        rst_n = 1'b0;
        ramp  = 1'b0;
        repeat (3) @(negedge clk);

        // Held in reset.
        check("a_rst_x",     a_if.x, 0);
        check("a_rst_y",     a_if.y, 0);
        check("a_rst_hsync", a_if.hsync, 1);
        check("a_rst_vsync", a_if.vsync, 1);
        check("a_rst_rgb",   a_if.vga_rgb, 0);
        check("a_rst_en",    a_if.en, 1);
        check("a_rst_fs",    a_if.frame_start, 0);
        check("b_rst_tick",  b_if.pix_tick, 1);

        rst_n = 1'b1;
        cur   = 0;
        for (int i = 0; i < 12; i++) begin
            if (vec[i].n > cur) begin
                repeat (vec[i].n - cur) @(posedge clk);
                @(negedge clk);
                cur = vec[i].n;
            end
            check($sformatf("vec%0d_x", i),     a_if.x,        vec[i].x);
            check($sformatf("vec%0d_y", i),     a_if.y,        vec[i].y);
            check($sformatf("vec%0d_tick", i),  a_if.pix_tick, vec[i].tick);
            check($sformatf("vec%0d_en", i),    a_if.en,       vec[i].en);
            check($sformatf("vec%0d_hsync", i), a_if.hsync,    vec[i].hs);
            check($sformatf("vec%0d_vsync", i), a_if.vsync,    vec[i].vs);
            check($sformatf("vec%0d_rgb", i),   a_if.vga_rgb,  vec[i].rgb);
        end

        // Alignment over line 1: rgb_in = x[7:0] delayed 3 clk must come out as each pixel's own x.
        ramp     = 1'b1;
        bad_rgb  = 0;
        bad_hs   = 0;
        hs_low   = 0;
        hs_fall  = -1;
        vs_low   = 0;
        first_px = 8'hAA;
        last_px  = 8'hAA;
        for (int n = 3205; n <= 6403; n++) begin
            int p, xe, ye;
            logic [7:0] e_rgb;
            logic       e_hs;
            @(posedge clk);
            @(negedge clk);
            p     = (n - 4) / 4;
            xe    = p % 800;
            ye    = p / 800;
            e_rgb = (xe < 640 && ye < 480) ? xe[7:0] : 8'h00;
            e_hs  = !(xe >= 656 && xe < 752);
            if (a_if.vga_rgb !== e_rgb) begin
                if (bad_rgb == 0)
                    $display("FAIL align_rgb@%0d: got %0h, expected %0h", n, a_if.vga_rgb, e_rgb);
                bad_rgb++;
            end
            if (a_if.hsync !== e_hs) bad_hs++;
            if (a_if.hsync === 1'b0) begin
                if (hs_fall < 0) hs_fall = n;
                hs_low++;
            end
            if (a_if.vsync !== 1'b1) vs_low++;
            if (n == 3205) first_px = a_if.vga_rgb;
            if (n == 5763) last_px  = a_if.vga_rgb;
        end
        tests++;
        if (bad_rgb != 0) fails++;
        check("line_hsync_model", bad_hs, 0);
        check("line_hsync_width", hs_low, 384);
        check("line_hsync_fall",  hs_fall, 5828);
        check("line_vsync_high",  vs_low, 0);
        check("first_active_px",  first_px, 8'h00);
        check("last_active_px",   last_px, 8'h7F);
        check("line_wrap_x",      a_if.x, 0);
        check("line_wrap_y",      a_if.y, 2);

        // Tiny raster, CLK_DIV=1, PIPE_LAT=0: 15x10 totals, 150 clk per frame.
        rst_n = 1'b0;
        @(negedge clk);
        check("b_rst2_tick", b_if.pix_tick, 1);
        check("b_rst2_en",   b_if.en, 1);
        rst_n     = 1'b1;
        bad_xy    = 0;
        bad_bhs   = 0;
        bad_bvs   = 0;
        bad_brgb  = 0;
        bad_fs    = 0;
        fs_cnt    = 0;
        fs_first  = -1;
        fs_second = -1;
        for (int m = 1; m <= 320; m++) begin
            int xm, ym, xp, yp;
            @(posedge clk);
            @(negedge clk);
            xm = m % 15;
            ym = (m / 15) % 10;
            xp = (m - 1) % 15;
            yp = ((m - 1) / 15) % 10;
            if (b_if.x !== 10'(xm) || b_if.y !== 10'(ym)) bad_xy++;
            if (b_if.hsync !== !(xp >= 10 && xp < 13)) bad_bhs++;
            if (b_if.vsync !== !(yp >= 7 && yp < 9)) bad_bvs++;
            if (b_if.vga_rgb !== ((xp < 8 && yp < 6) ? 8'hFF : 8'h00)) bad_brgb++;
            if (b_if.frame_start !== (m % 150 == 0)) bad_fs++;
            if (b_if.frame_start === 1'b1) begin
                fs_cnt++;
                if (fs_first < 0) fs_first = m;
                else if (fs_second < 0) fs_second = m;
            end
        end
        check("frame_xy",         bad_xy, 0);
        check("frame_hsync",      bad_bhs, 0);
        check("frame_vsync",      bad_bvs, 0);
        check("frame_blank_rgb",  bad_brgb, 0);
        check("frame_start_seq",  bad_fs, 0);
        check("frame_start_cnt",  fs_cnt, 2);
        check("frame_start_pos",  fs_first, 150);
        check("frame_period",     fs_second - fs_first, 150);

        // Asynchronous reset in the middle of an hsync+vsync pulse (x=11, y=7).
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (116) @(posedge clk);
        @(negedge clk);
        check("mid_pre_x",     b_if.x, 11);
        check("mid_pre_y",     b_if.y, 7);
        check("mid_pre_hsync", b_if.hsync, 0);
        check("mid_pre_vsync", b_if.vsync, 0);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_x",     b_if.x, 0);
        check("mid_rst_y",     b_if.y, 0);
        check("mid_rst_hsync", b_if.hsync, 1);
        check("mid_rst_vsync", b_if.vsync, 1);
        check("mid_rst_rgb",   b_if.vga_rgb, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("restart_x1",    b_if.x, 1);
        check("restart_hsync", b_if.hsync, 1);
        check("restart_vsync", b_if.vsync, 1);
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("restart_x3",    b_if.x, 3);
        check("restart_y",     b_if.y, 0);
        check("restart_tick",  b_if.pix_tick, 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/vga_timing_gen.md
# vga_timing_gen

Generates 640x480@60 Hz VGA raster timing from the system clock and closes the loop on the sprite pipeline. It drives pixel coordinates and the active-video enable into the cell sprite renderers, then takes their composited `rgb` back. It outputs blanked colour plus HSYNC/VSYNC, delayed so that sync lines up with the sprites' fixed pipeline latency. It sits between the sprite/compositor logic and the VGA connector.

## Interface
- `CLK_DIV`, 4, clk cycles per pixel (100 MHz to 25 MHz); legal range 1..16
- `H_ACTIVE`, 640 / `H_FP`, 16 / `H_SYNC`, 96 / `H_BP`, 48, horizontal timing in pixels
- `V_ACTIVE`, 480 / `V_FP`, 10 / `V_SYNC`, 2 / `V_BP`, 33, vertical timing in lines
- `PIPE_LAT`, 3, clk cycles from `x`/`y` change to the matching `rgb_in`; legal range 0..15
- `clk` input 1 system clock; one clock domain only
- `rst_n` input 1 asynchronous, active-low reset
- `x` output 10 horizontal counter, 0..H_TOTAL-1
- `y` output 10 vertical counter, 0..V_TOTAL-1
- `en` output 1 active video: x < H_ACTIVE && y < V_ACTIVE
- `pix_tick` output 1 one-clk pulse each pixel period
- `frame_start` output 1 one-clk pulse when counters wrap to (0,0)
- `rgb_in` input 8 composited colour for the coordinates presented PIPE_LAT cycles earlier
- `vga_rgb` output 8 blanked colour to DAC
- `hsync` output 1 active low
- `vsync` output 1 active low

## Operation
- Totals: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP = 800; V_TOTAL = 525.
- Divider: `div_cnt` counts 0..CLK_DIV-1 and wraps. `pix_tick` is asserted combinationally while `div_cnt == CLK_DIV-1`. With CLK_DIV=1, `pix_tick` is constantly 1.
- On a clk edge with `pix_tick`:
  - `x` increments.
  - At `x == H_TOTAL-1`, `x` goes to 0 and `y` increments.
  - At `y == V_TOTAL-1` on that same wrap, `y` goes to 0 and `frame_start` is registered high for exactly one clk.
- Counters change only on `pix_tick` edges.
- Raw decodes are combinational from `x`/`y`:
  - `hs_raw` = 0 when H_ACTIVE+H_FP <= x < H_ACTIVE+H_FP+H_SYNC (656..751).
  - `vs_raw` = 0 when V_ACTIVE+V_FP <= y < V_ACTIVE+V_FP+V_SYNC (490..491).
  - `act_raw` = `en`.
- Delay line: `{act_raw, hs_raw, vs_raw}` shift through PIPE_LAT clk-stage registers. PIPE_LAT=0 means a direct connection.
- Output register, updated every clk:
  - `hsync <= hs_d`, `vsync <= vs_d`
  - `vga_rgb <= act_d ? rgb_in : 8'h00`
- `rgb_in` is never passed through during blanking, whatever its value.

## Timing
- Reset values (asynchronous, while `rst_n` = 0):
  - `div_cnt` = 0, `x` = 0, `y` = 0, `frame_start` = 0
  - `hsync` = 1, `vsync` = 1, `vga_rgb` = 0
  - Delay stages cleared to act=0, hs=1, vs=1
  - `en` = 1, because (0,0) is active; `pix_tick` = 1 only if CLK_DIV = 1
- First `x` increment happens CLK_DIV edges after reset release.
- Latency:
  - `x`/`y` change to `en` change: 0 clk.
  - `hs_raw` to `hsync`: PIPE_LAT+1 clk.
  - `rgb_in` to `vga_rgb`: 1 clk.
- Pixel (x,y) therefore appears on `vga_rgb` in the same clk as its sync/blank state.
- Reset asserted mid-frame: all state returns to the reset values immediately. The frame restarts at (0,0) with no partial sync pulse carried over.
- Simultaneous H wrap and V wrap on one tick: both happen in that single edge, and `frame_start` pulses.
- Line period = H_TOTAL·CLK_DIV clk = 3200.
- Frame period = 525 lines = 1,680,000 clk.

## Structure
- The shared package `vga_pkg` holds:
  - Default timing constants.
  - Derived H_TOTAL and V_TOTAL.
  - The 10-bit coordinate width constant.
- One sub-module, `sync_delay`: a parameterised WIDTH×DEPTH shift register with async active-low reset and a per-bit reset value. It is instantiated once, with WIDTH=3 and DEPTH=PIPE_LAT.
- The top level holds the divider, counters, decodes and output register.

## Test plan
- Reset release: `x`=0, `y`=0, `hsync`=1, `vsync`=1, `vga_rgb`=0. With CLK_DIV=4, `pix_tick` pulses every 4th clk and `x`=1 after 4 edges.
- Full line:
  - `hsync` goes low 96 pixels (384 clk) long, PIPE_LAT+1 clk after `x` reaches 656.
  - `x` wraps 799 to 0 and `y` increments exactly once.
- Full frame:
  - `vsync` is low for lines 490–491 only.
  - `frame_start` is a single 1-clk pulse at (799,524) to (0,0).
  - Frame period is 1,680,000 clk.
- Blanking, with `rgb_in` tied to 8'hFF: `vga_rgb` is 8'hFF only for delayed-active pixels and 8'h00 in every porch and sync pixel.
- Alignment, with PIPE_LAT=3 and `rgb_in` = `x[7:0]` delayed 3 clk: `vga_rgb` equals the pixel's own `x` across the whole line. The first active pixel shows 8'h00 and the last shows 8'h7F (639 & 255).
- Reset pulse mid-line at x=700, y=490:
  - Outputs jump to reset values asynchronously, including `vsync` back to 1.
  - Timing restarts from (0,0); CLK_DIV=1 regression gives one pixel per clk.
